vga_scan_driver: RTL

//  Generates VGA raster timing and drives the pixel-request interface (pixel_x/pixel_y/pixel_valid)

---
 rtl/vga_scan_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// rtl/vga_scan_driver.sv - VGA raster timing, pixel-request decode and pipeline-aligned pin driver
//
// Ports:
//   clk, rst_n                   pixel clock, asynchronous active-low reset
//   enable                       scan run request (registered into run)
//   rgb_r_in/g_in/b_in [7:0]     renderer colour for the pixel issued PIPE_LAT clocks earlier
//   pixel_x/pixel_y [9:0]        current raster coordinate (straight from the counters)
//   pixel_valid                  coordinate is inside the visible area while running
//   frame_start                  one-clock pulse at (0,0) while running
//   vga_hs/vga_vs                sync pins, delayed to line up with the colour pins
//   vga_r/vga_g/vga_b [7:0]      registered colour pins, zero outside the visible area
module vga_scan_driver #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   PIPE_LAT = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] rgb_r_in,
    input  logic [7:0] rgb_g_in,
    input  logic [7:0] rgb_b_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_params
            $error("vga_scan_driver: timing sums must be <= 1024 and PIPE_LAT within 0..7");
        end
    endgenerate

    // Comparisons are done on 11 bits so a sync window ending exactly at 1024 still decodes.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       run_q, run_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [7:0] vga_r_q, vga_r_d;
    logic [7:0] vga_g_q, vga_g_d;
    logic [7:0] vga_b_q, vga_b_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;

    logic [10:0] h_ext, v_ext;
    logic        hs_raw, vs_raw;
    logic        valid_d, hs_d, vs_d;

    assign h_ext = {1'b0, h_cnt_q};
    assign v_ext = {1'b0, v_cnt_q};

    // Counters sit at (0,0) while idle so a re-enabled scan always starts a fresh frame.
    always_comb begin
        run_d   = enable;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!run_q) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
    end

    always_comb begin
        pixel_valid = run_q && (h_ext < H_VIS) && (v_ext < V_VIS);
        frame_start = run_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        hs_raw      = (run_q && h_ext >= HS_START && h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_raw      = (run_q && v_ext >= VS_START && v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
    end

    // Delay line keeps blank/sync in step with the renderer's colour latency.
    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign valid_d = pixel_valid;
            assign hs_d    = hs_raw;
            assign vs_d    = vs_raw;
        end else begin : g_delay
            logic [2:0] dly_q [PIPE_LAT];
            logic [2:0] dly_d [PIPE_LAT];

            always_comb begin
                dly_d[0] = {pixel_valid, hs_raw, vs_raw};
                for (int i = 1; i < PIPE_LAT; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_q[i] <= {1'b0, ~SYNC_POL, ~SYNC_POL};
                    end
                end else begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign {valid_d, hs_d, vs_d} = dly_q[PIPE_LAT-1];
        end
    endgenerate

    always_comb begin
        vga_r_d  = valid_d ? rgb_r_in : 8'd0;
        vga_g_d  = valid_d ? rgb_g_in : 8'd0;
        vga_b_d  = valid_d ? rgb_b_in : 8'd0;
        vga_hs_d = hs_d;
        vga_vs_d = vs_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= ~SYNC_POL;
            vga_vs_q <= ~SYNC_POL;
        end else begin
            run_q    <= run_d;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
        end
    end

    assign pixel_x = h_cnt_q;
    assign pixel_y = v_cnt_q;
    assign vga_r   = vga_r_q;
    assign vga_g   = vga_g_q;
    assign vga_b   = vga_b_q;
    assign vga_hs  = vga_hs_q;
    assign vga_vs  = vga_vs_q;

endmodule
